// File: rtl/visor_program_ram.sv
// visor_program_ram: writable program store for the visor core.
// Fetch port: one registered read per cycle.
// Load port: a framed byte stream (header, 16-bit word count, data, checksum) rewrites
// the array. The core is held while a frame is in flight.
module visor_program_ram #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CHECK,
    RESULT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [15:0]           count;     // word count N of the current frame
  logic [7:0]            sum;       // running modulo-256 checksum
  logic [ADDR_WIDTH:0]   wcount;    // words written so far; low bits are the write address
  logic [LW-1:0]         lane;      // byte position inside the word being assembled
  logic [DATA_WIDTH-1:0] asm_word;  // lower lanes of the word being assembled
  logic                  pass;      // frame outcome, valid in RESULT

  logic                  accept;
  logic                  is_header;
  logic                  last_lane;
  logic                  last_word;
  logic                  oversize;
  logic                  wr_en;
  logic [7:0]            sum_nxt;
  logic [DATA_WIDTH-1:0] word_nxt;

  assign accept    = load_valid && load_ready;
  assign is_header = (load_byte == HEADER_BYTE);
  assign last_lane = (lane == LW'(BYTES - 1));
  assign last_word = ((17'(wcount) + 17'd1) == {1'b0, count});
  assign oversize  = ({1'b0, load_byte, count[7:0]} > 17'(DEPTH));
  assign wr_en     = (state == DATA) && accept && last_lane;
  assign sum_nxt   = sum + load_byte;

  // Merge the incoming byte into its lane so the final byte can be written with its word.
  always_comb begin
    word_nxt = asm_word;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (lane == LW'(i)) word_nxt[i*8 +: 8] = load_byte;
    end
  end

  // Program array write port (no reset: contents survive reset).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wcount[ADDR_WIDTH-1:0]] <= word_nxt;
  end

  // Registered fetch; a same-cycle write to the same address returns the old word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_data <= '0;
    else          fetch_data <= mem[fetch_addr];
  end

  // Loader state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Loader next-state: frame parsing; stalls whenever no byte is accepted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && is_header) state_nxt = CNT_LO;
      CNT_LO:  if (accept) state_nxt = CNT_HI;
      CNT_HI: begin
        if (accept) begin
          if (oversize)                              state_nxt = RESULT;
          else if ({load_byte, count[7:0]} == 16'd0) state_nxt = CHECK;
          else                                       state_nxt = DATA;
        end
      end
      DATA:    if (accept && last_lane && last_word) state_nxt = CHECK;
      CHECK:   if (accept) state_nxt = RESULT;
      RESULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loader outputs decoded from the state; RESULT is the single handshake-blocked cycle.
  always_comb begin
    load_ready = (state != RESULT);
    cpu_hold   = (state != IDLE);
    load_done  = (state == RESULT) && pass;
    load_error = (state == RESULT) && !pass;
  end

  // Loader datapath: count capture, checksum, word assembly and result latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      sum          <= '0;
      wcount       <= '0;
      lane         <= '0;
      asm_word     <= '0;
      pass         <= 1'b0;
      words_loaded <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && is_header) sum <= '0;
        end
        CNT_LO: begin
          if (accept) begin
            count[7:0] <= load_byte;
            sum        <= sum_nxt;
          end
        end
        CNT_HI: begin
          if (accept) begin
            count[15:8] <= load_byte;
            sum         <= sum_nxt;
            wcount      <= '0;
            lane        <= '0;
            // An oversize count goes straight to RESULT and must report failure.
            pass        <= 1'b0;
          end
        end
        DATA: begin
          if (accept) begin
            sum      <= sum_nxt;
            asm_word <= word_nxt;
            if (last_lane) begin
              lane   <= '0;
              wcount <= wcount + (ADDR_WIDTH+1)'(1);
            end else begin
              lane   <= lane + LW'(1);
            end
          end
        end
        CHECK: begin
          if (accept) begin
            sum  <= sum_nxt;
            pass <= (sum_nxt == 8'h00);
          end
        end
        RESULT: begin
          if (pass) words_loaded <= (ADDR_WIDTH+1)'(count);
        end
        default: ;
      endcase
    end
  end

endmodule
